// File: rtl/mixer_ddc_core.sv
// Receive-side complex down-converter: (I + jQ) * (cos - j*sin) from a 16-entry NCO table in a
// 4-stage stallable valid/ready pipeline. Define MIXER_DDC_ROUND_EN for round-half-up in stage 4.
module mixer_ddc_core #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LO_W    = 8,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned SHIFT   = 7
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [PHASE_W-1:0]        phase_inc,
  input  logic                      phase_clr,
  input  logic signed [DATA_W-1:0]  s_i,
  input  logic signed [DATA_W-1:0]  s_q,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic signed [DATA_W-1:0]  m_i,
  output logic signed [DATA_W-1:0]  m_q,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      sat_flag,
  input  logic                      sat_clr
);

  localparam int unsigned ProdW = DATA_W + LO_W;
  localparam int unsigned SumW  = ProdW + 1;
  localparam int unsigned RndW  = SumW + 1;
  localparam int          OutMax = (1 << (DATA_W - 1)) - 1;
  localparam int          OutMin = -(1 << (DATA_W - 1));

  function automatic logic signed [LO_W-1:0] cos_lut(input logic [3:0] k);
    int v;
    case (k)
      4'd0:    v = 127;
      4'd1:    v = 117;
      4'd2:    v = 90;
      4'd3:    v = 49;
      4'd4:    v = 0;
      4'd5:    v = -49;
      4'd6:    v = -90;
      4'd7:    v = -117;
      4'd8:    v = -127;
      4'd9:    v = -117;
      4'd10:   v = -90;
      4'd11:   v = -49;
      4'd12:   v = 0;
      4'd13:   v = 49;
      4'd14:   v = 90;
      default: v = 117;
    endcase
    return LO_W'(v);
  endfunction

  logic                     adv, accept;
  logic [PHASE_W-1:0]       acc_q, acc_d;
  logic [3:0]               idx;
  logic                     v1_q, v2_q, v3_q, m_valid_q;
  logic signed [DATA_W-1:0] i1_q, q1_q;
  logic signed [LO_W-1:0]   c1_q, s1_q;
  logic signed [ProdW-1:0]  p_ic_q, p_qs_q, p_qc_q, p_is_q;
  logic signed [SumW-1:0]   sum_i_q, sum_q_q;
  logic signed [RndW-1:0]   rnd_i, rnd_q, shf_i, shf_q;
  logic signed [DATA_W-1:0] sat_i, sat_q, m_i_q, m_q_q;
  logic                     clip_i, clip_q;
  logic                     sat_flag_q, sat_flag_d;

  // Whole pipeline moves in lockstep; bubbles are kept, not squeezed.
  assign adv     = !m_valid_q || m_ready;
  assign accept  = s_valid && adv;
  assign s_ready = adv;
  assign idx     = acc_q[PHASE_W-1 -: 4];

  always_comb begin
    acc_d = acc_q;
    if (phase_clr) begin
      acc_d = '0;
    end else if (accept) begin
      acc_d = acc_q + phase_inc;
    end
  end

  always_comb begin
    rnd_i = RndW'(sum_i_q);
    rnd_q = RndW'(sum_q_q);
`ifdef MIXER_DDC_ROUND_EN
    rnd_i = rnd_i + RndW'(1 << (SHIFT - 1));
    rnd_q = rnd_q + RndW'(1 << (SHIFT - 1));
`endif
    shf_i = rnd_i >>> SHIFT;
    shf_q = rnd_q >>> SHIFT;
    clip_i = 1'b1;
    clip_q = 1'b1;
    if (shf_i > RndW'(OutMax)) begin
      sat_i = DATA_W'(OutMax);
    end else if (shf_i < RndW'(OutMin)) begin
      sat_i = DATA_W'(OutMin);
    end else begin
      sat_i  = shf_i[DATA_W-1:0];
      clip_i = 1'b0;
    end
    if (shf_q > RndW'(OutMax)) begin
      sat_q = DATA_W'(OutMax);
    end else if (shf_q < RndW'(OutMin)) begin
      sat_q = DATA_W'(OutMin);
    end else begin
      sat_q  = shf_q[DATA_W-1:0];
      clip_q = 1'b0;
    end
  end

  // A clip on the load edge wins over a simultaneous clear.
  always_comb begin
    sat_flag_d = sat_flag_q;
    if (sat_clr) begin
      sat_flag_d = 1'b0;
    end
    if (adv && v3_q && (clip_i || clip_q)) begin
      sat_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q      <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      m_valid_q  <= 1'b0;
      m_i_q      <= '0;
      m_q_q      <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      sat_flag_q <= sat_flag_d;
      if (adv) begin
        v1_q      <= s_valid;
        v2_q      <= v1_q;
        v3_q      <= v2_q;
        m_valid_q <= v3_q;
        if (v3_q) begin
          m_i_q <= sat_i;
          m_q_q <= sat_q;
        end
      end
    end
  end

  // Datapath registers need no reset; their contents only matter under a valid bit.
  always_ff @(posedge clk) begin
    if (adv) begin
      i1_q    <= s_i;
      q1_q    <= s_q;
      c1_q    <= cos_lut(idx);
      s1_q    <= cos_lut(idx - 4'd4);
      p_ic_q  <= ProdW'(i1_q) * ProdW'(c1_q);
      p_qs_q  <= ProdW'(q1_q) * ProdW'(s1_q);
      p_qc_q  <= ProdW'(q1_q) * ProdW'(c1_q);
      p_is_q  <= ProdW'(i1_q) * ProdW'(s1_q);
      sum_i_q <= SumW'(p_ic_q) + SumW'(p_qs_q);
      sum_q_q <= SumW'(p_qc_q) - SumW'(p_is_q);
    end
  end

  assign m_i      = m_i_q;
  assign m_q      = m_q_q;
  assign m_valid  = m_valid_q;
  assign sat_flag = sat_flag_q;

endmodule

// File: tb/tb_mixer_ddc_core.sv
// Self-checking bench for mixer_ddc_core: vector table plus hand sequences, all outputs
// checked in order against a scoreboard queue filled at each accepted input.
module tb_mixer_ddc_core;

  localparam int COS_T [16] = '{127, 117, 90, 49, 0, -49, -90, -117,
                                -127, -117, -90, -49, 0, 49, 90, 117};

  typedef struct {
    logic [15:0] inc;
    int          in_i;
    int          in_q;
    int          ex_i;
    int          ex_q;
  } vec_t;

  typedef struct {
    int i;
    int q;
  } exp_t;

  logic               clk = 1'b0;
  logic               rstn;
  logic [15:0]        phase_inc;
  logic               phase_clr;
  logic signed [15:0] s_i, s_q;
  logic               s_valid, s_ready;
  logic signed [15:0] m_i, m_q;
  logic               m_valid, m_ready;
  logic               sat_flag, sat_clr;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [15:0] model_acc = '0;
  bit   use_tbl = 1'b0;
  int   tbl_ei, tbl_eq;
  bit   prev_stall = 1'b0;
  int   prev_i, prev_q;
  vec_t tbl[11];

  mixer_ddc_core dut (
    .clk       (clk),
    .rstn      (rstn),
    .phase_inc (phase_inc),
    .phase_clr (phase_clr),
    .s_i       (s_i),
    .s_q       (s_q),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_i       (m_i),
    .m_q       (m_q),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .sat_flag  (sat_flag),
    .sat_clr   (sat_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clip16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic exp_t model(input int i, input int q, input int k);
    exp_t e;
    int c, s, si, sq;
    c  = COS_T[k];
    s  = COS_T[(k + 12) % 16];
    si = i * c + q * s;
    sq = q * c - i * s;
`ifdef MIXER_DDC_ROUND_EN
    si = si + 64;
    sq = sq + 64;
`endif
    e.i = clip16(si >>> 7);
    e.q = clip16(sq >>> 7);
    return e;
  endfunction

  // Monitor: inputs change only at posedge+1, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      sb.delete();
      model_acc  = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_i", int'(m_i), prev_i);
        chk("hold_q", int'(m_q), prev_q);
      end
      if (s_valid && s_ready) begin
        e = model(int'(s_i), int'(s_q), int'(model_acc[15:12]));
`ifndef MIXER_DDC_ROUND_EN
        if (use_tbl) begin
          e.i = tbl_ei;
          e.q = tbl_eq;
        end
`endif
        sb.push_back(e);
        model_acc = phase_clr ? 16'h0 : model_acc + phase_inc;
      end else if (phase_clr) begin
        model_acc = '0;
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got i=%0d q=%0d, expected none", m_i, m_q);
        end else begin
          e = sb.pop_front();
          chk("out_i", int'(m_i), e.i);
          chk("out_q", int'(m_q), e.q);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_i     = int'(m_i);
      prev_q     = int'(m_q);
    end
  end

  task automatic send(input int i, input int q, input logic [15:0] inc, input bit tb_exp,
                      input int ei, input int eq, input bit clr);
    bit ok;
    s_i       = 16'(i);
    s_q       = 16'(q);
    phase_inc = inc;
    phase_clr = clr;
    use_tbl   = tb_exp;
    tbl_ei    = ei;
    tbl_eq    = eq;
    s_valid   = 1'b1;
    ok        = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid   = 1'b0;
    phase_clr = 1'b0;
    use_tbl   = 1'b0;
  endtask

  task automatic drain();
    bit done;
    m_ready = 1'b1;
    done    = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    chk("drain_pending", sb.size(), 0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    int n, cyc;
    tbl[0]  = '{16'h4000, 1000, 0, 992, 0};
    tbl[1]  = '{16'h4000, 1000, 0, 0, -993};
    tbl[2]  = '{16'h4000, 1000, 0, -993, 0};
    tbl[3]  = '{16'h4000, 1000, 0, 0, 992};
    tbl[4]  = '{16'h2000, 32767, 32767, 32511, 32511};
    tbl[5]  = '{16'h2000, 32767, 32767, 32767, 0};
    tbl[6]  = '{16'h0000, -32768, -32768, -32512, 32512};
    tbl[7]  = '{16'h2000, -32768, -32768, -32512, 32512};
    tbl[8]  = '{16'h2000, -32768, 32767, 32767, 0};
    tbl[9]  = '{16'h2000, 32767, -32768, -32512, 32512};
    tbl[10] = '{16'h0000, 32767, 32767, -32768, 0};

    rstn = 1'b0; phase_inc = '0; phase_clr = 1'b0; s_i = '0; s_q = '0;
    s_valid = 1'b0; m_ready = 1'b1; sat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_i", int'(m_i), 0);
    chk("rst_m_q", int'(m_q), 0);
    chk("rst_sat_flag", int'(sat_flag), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Latency: first m_valid exactly 4 edges after the first accept.
    s_i = 16'sd1000; s_q = '0; phase_inc = '0;
    use_tbl = 1'b1; tbl_ei = 992; tbl_eq = 0;
    s_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("latency_edge%0d", k), int'(m_valid), (k == 4) ? 1 : 0);
    end
    s_valid = 1'b0;
    use_tbl = 1'b0;
    drain();
    chk("sat_flag_clean", int'(sat_flag), 0);

    phase_clr = 1'b1;
    @(posedge clk);
    #1;
    phase_clr = 1'b0;
    for (int v = 0; v < 11; v++) begin
      send(tbl[v].in_i, tbl[v].in_q, tbl[v].inc, 1'b1, tbl[v].ex_i, tbl[v].ex_q, 1'b0);
    end
    drain();
    chk("sat_flag_set", int'(sat_flag), 1);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    chk("sat_flag_cleared", int'(sat_flag), 0);

    // phase_clr mid-stream: clear-cycle sample keeps its index, the next one uses index 0.
    for (int k = 0; k < 3; k++) send(1000, 0, 16'h1000, 1'b0, 0, 0, 1'b0);
    send(1000, 0, 16'h1000, 1'b0, 0, 0, 1'b1);
    send(1000, 0, 16'h1000, 1'b1, 992, 0, 1'b0);
    send(1000, 0, 16'h1000, 1'b1, 914, -383, 1'b0);
    drain();

    // Random valid and backpressure over a 64-sample ramp.
    n = 0;
    cyc = 0;
    phase_inc = 16'h1357;
    while (n < 64 && cyc < 4000) begin
      s_i     = 16'(n * 997 - 32000);
      s_q     = 16'(20000 - n * 800);
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s_valid && s_ready) n++;
      @(posedge clk);
      #1;
      cyc++;
    end
    s_valid = 1'b0;
    chk("random_accepted", n, 64);
    drain();

    // Asynchronous reset with samples in flight.
    for (int k = 0; k < 5; k++) send(32767, 32767, 16'h2000, 1'b0, 0, 0, 1'b0);
    chk("pre_reset_valid", int'(m_valid), 1);
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", int'(m_valid), 0);
    chk("async_rst_i", int'(m_i), 0);
    chk("async_rst_sat", int'(sat_flag), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    send(500, 300, 16'h1000, 1'b1, 496, 297, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
